alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_sequencer.sv | 93 +++++++++
 tb/tb_alu_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and sequencer FSM state type shared by the ALU and alu_sequencer.
package alu_pkg;
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SHL  = 3'b101;
   localparam logic [2:0] OP_SHR  = 3'b110;
   localparam logic [2:0] OP_RSVD = 3'b111;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one command at a time to an external ALU and registers its response.
// ALU_SEQ_RSVD_TRAP_EN: opcode 111 is accepted in IDLE and answered only by a one-cycle err pulse.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int d_Width = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_opcode,
   input  logic [d_Width-1:0] cmd_opA,
   input  logic [d_Width-1:0] cmd_opB,
   input  logic               cmd_use_acc,
   output logic [d_Width-1:0] alu_opA,
   output logic [d_Width-1:0] alu_opB,
   output logic [2:0]         alu_opcode,
   input  logic [d_Width-1:0] alu_result,
   input  logic               alu_carry,
   input  logic               alu_zero,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [d_Width-1:0] rsp_result,
   output logic               rsp_carry,
   output logic               rsp_zero,
   output logic [d_Width-1:0] acc,
   output logic               err
);
   state_t             r_state, w_next;
   logic [d_Width-1:0] r_opA, r_opB, r_result, r_acc;
   logic [2:0]         r_opc;
   logic               r_carry, r_zero, w_rsvd, w_take;

   assign w_take = (r_state == S_IDLE) && cmd_valid;

`ifdef ALU_SEQ_RSVD_TRAP_EN
   logic r_err;
   assign w_rsvd = (cmd_opcode == OP_RSVD);
   always_ff @(posedge clk)
      r_err <= !rst && w_take && w_rsvd;
   assign err = r_err;
`else
   assign w_rsvd = 1'b0;
   assign err    = 1'b0;
`endif

   always_ff @(posedge clk)
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;

   always_comb
      w_next = (r_state == S_IDLE) ? ((cmd_valid && !w_rsvd) ? S_EXEC : S_IDLE) :
               (r_state == S_EXEC) ? S_RESP :
               (rsp_ready ? S_IDLE : S_RESP);

   always_comb begin
      cmd_ready = (r_state == S_IDLE) && !rst;
      rsp_valid = (r_state == S_RESP);
   end

   always_ff @(posedge clk)
      if (rst) begin
         r_opc    <= OP_ADD;
         r_opA    <= '0;
         r_opB    <= '0;
         r_result <= '0;
         r_acc    <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
      end else begin
         if (w_take && !w_rsvd) begin
            r_opc <= cmd_opcode;
            r_opA <= cmd_use_acc ? r_acc : cmd_opA;
            r_opB <= cmd_opB;
         end
         // The ALU reports the sum carry for every opcode; only ADD keeps it.
         if (r_state == S_EXEC) begin
            r_result <= alu_result;
            r_acc    <= alu_result;
            r_zero   <= alu_zero;
            r_carry  <= alu_carry && (r_opc == OP_ADD);
         end
      end

   assign alu_opA    = r_opA;
   assign alu_opB    = r_opB;
   assign alu_opcode = r_opc;
   assign rsp_result = r_result;
   assign rsp_carry  = r_carry;
   assign rsp_zero   = r_zero;
   assign acc        = r_acc;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer with a behavioural ALU and checks it against a spec-level model.
module tb_alu_sequencer;
   logic       clk = 1'b0, rst = 1'b1;
   logic       cmd_valid = 1'b0, cmd_use_acc = 1'b0, rsp_ready = 1'b0;
   logic [2:0] cmd_opcode = 3'd0;
   logic [7:0] cmd_opA = 8'd0, cmd_opB = 8'd0;
   logic       cmd_ready, rsp_valid, rsp_carry, rsp_zero, err, alu_carry, alu_zero;
   logic [7:0] alu_opA, alu_opB, alu_result, rsp_result, acc;
   logic [2:0] alu_opcode;
   int         n_tests = 0, n_fail = 0;
   int         m_acc = 0;
`ifdef ALU_SEQ_RSVD_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return a << b;
         3'd6: return a >> b;
         default: return 8'd0;
      endcase
   endfunction

   assign alu_result = alu_f(alu_opcode, alu_opA, alu_opB);
   assign alu_carry  = ({1'b0, alu_opA} + {1'b0, alu_opB}) > 9'd255;
   assign alu_zero   = (alu_result == 8'd0);

   alu_sequencer #(.d_Width(8)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_opA(cmd_opA), .cmd_opB(cmd_opB), .cmd_use_acc(cmd_use_acc),
      .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .acc(acc), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference result from plain integer arithmetic on the opcode table.
   function automatic int ref_res(input int op, input int a, input int b);
      case (op)
         0: return (a + b) % 256;
         1: return (a - b + 256) % 256;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return (b >= 8) ? 0 : ((a << b) & 255);
         6: return (b >= 8) ? 0 : (a >> b);
         default: return 0;
      endcase
   endfunction

   task automatic do_cmd(input int op, input int a, input int b, input bit ua, input int hold);
      int ea, er, ec;
      ea = ua ? m_acc : a;
      chk("ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_opcode = op[2:0]; cmd_opA = a[7:0]; cmd_opB = b[7:0]; cmd_use_acc = ua;
      @(negedge clk);
      cmd_valid = 1'b0;
      if (TRAP && op == 7) begin
         chk("trap_err", err, 1);
         chk("trap_valid", rsp_valid, 0);
         chk("trap_ready", cmd_ready, 1);
         chk("trap_acc", acc, m_acc);
         @(negedge clk);
         chk("trap_err_drop", err, 0);
         chk("trap_valid2", rsp_valid, 0);
         return;
      end
      er = ref_res(op, ea, b);
      ec = (op == 0 && ea + b > 255) ? 1 : 0;
      chk("exec_valid", rsp_valid, 0);
      chk("exec_ready", cmd_ready, 0);
      chk("exec_opA", alu_opA, ea);
      chk("exec_opB", alu_opB, b);
      chk("exec_opc", alu_opcode, op);
      @(negedge clk);
      m_acc = er;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_result", rsp_result, er);
      chk("rsp_carry", rsp_carry, ec);
      chk("rsp_zero", rsp_zero, er == 0);
      chk("rsp_acc", acc, er);
      chk("rsp_err", err, 0);
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'($urandom); cmd_opcode = 3'($urandom);
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_result", rsp_result, er);
         chk("hold_carry", rsp_carry, ec);
         chk("hold_ready", cmd_ready, 0);
         chk("hold_opA", alu_opA, ea);
      end
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("done_valid", rsp_valid, 0);
      chk("done_ready", cmd_ready, 1);
      chk("done_acc", acc, er);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_valid", rsp_valid, 0);
      rst = 1'b0;
      #1;
      chk("rel_ready", cmd_ready, 1);
      chk("rel_valid", rsp_valid, 0);
      chk("rel_result", rsp_result, 0);
      chk("rel_flags", {rsp_carry, rsp_zero, err}, 0);
      chk("rel_acc", acc, 0);
      chk("rel_issue", {alu_opcode, alu_opA, alu_opB}, 0);
      @(negedge clk);
      do_cmd(0, 'hF0, 'h20, 1'b0, 0);
      do_cmd(1, 'h00, 'h10, 1'b1, 5);
      do_cmd(4, 'h5A, 'h3C, 1'b0, 2);
      do_cmd(7, 'h12, 'h34, 1'b0, 1);
      do_cmd(2, 'h00, 'hFF, 1'b1, 0);
      // Reset while the ADD sits in EXEC must drop it entirely.
      chk("rx_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_opcode = 3'd0; cmd_opA = 8'h01; cmd_opB = 8'h01; cmd_use_acc = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("rx_exec", rsp_valid, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("rx_valid", rsp_valid, 0);
      chk("rx_acc", acc, 0);
      chk("rx_ready_rst", cmd_ready, 0);
      rst = 1'b0;
      m_acc = 0;
      @(negedge clk);
      chk("rx_idle", cmd_ready, 1);
      chk("rx_valid2", rsp_valid, 0);
      chk("rx_acc2", acc, 0);
      do_cmd(0, 'hFF, 'h01, 1'b0, 1);
      do_cmd(5, 'h81, 'h01, 1'b0, 0);
      do_cmd(6, 'h80, 'h09, 1'b0, 0);
      for (int k = 0; k < 40; k++)
         do_cmd(int'($urandom_range(7)), int'($urandom_range(255)), int'($urandom_range(255)),
                1'($urandom), int'($urandom_range(3)));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
